// File: rtl/samp_capture_buf.sv
// rtl/samp_capture_buf.sv - sample capture buffer with arm/stop control, one-shot and circular modes
// Optional decimation input is enabled by defining SAMP_CAP_DECIM_EN.
module samp_capture_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [DATA_W-1:0]           SAMP_DATA,
   input  logic                        SAMP_VALID,
   input  logic                        ARM,
   input  logic                        MODE,
   input  logic                        STOP,
`ifdef SAMP_CAP_DECIM_EN
   input  logic [7:0]                  DECIM,
`endif
   input  logic [$clog2(DEPTH)-1:0]    RD_ADDR,
   output logic [DATA_W-1:0]           RD_DATA,
   output logic [$clog2(DEPTH):0]      SAMP_CNTS,
   output logic [$clog2(DEPTH)-1:0]    WR_PTR,
   output logic                        BUSY,
   output logic                        DONE,
   output logic                        OVERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_mode;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_rd_data;
   logic [CW-1:0]       r_cnt;
   logic [AW-1:0]       r_wr_ptr;
   logic                r_ovf;
   logic                w_take;
   logic                w_accept;
   logic                w_last_oneshot;

`ifdef SAMP_CAP_DECIM_EN
   logic [7:0]          r_dec_cnt;

   // Counter position 0 marks the sample that gets stored.
   assign w_take = (r_dec_cnt == 8'd0);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_dec_cnt <= 8'd0;
      end else if (ARM) begin
         r_dec_cnt <= 8'd0;
      end else if (r_state == S_CAPTURE && SAMP_VALID) begin
         r_dec_cnt <= (r_dec_cnt >= DECIM) ? 8'd0 : r_dec_cnt + 8'd1;
      end
   end
`else
   assign w_take = 1'b1;
`endif

   // ARM has priority over any sample arriving in the same cycle.
   assign w_accept       = (r_state == S_CAPTURE) && SAMP_VALID && !ARM && w_take;
   assign w_last_oneshot = w_accept && !r_mode && (r_cnt == CW'(DEPTH - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (ARM) begin
            r_mode <= MODE;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (ARM) begin
         w_state_nxt = S_CAPTURE;
      end else begin
         case (r_state)
            S_CAPTURE: begin
               if (w_last_oneshot || (r_mode && STOP)) begin
                  w_state_nxt = S_DONE;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      BUSY = (r_state == S_CAPTURE);
      DONE = (r_state == S_DONE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt    <= '0;
         r_wr_ptr <= '0;
         r_ovf    <= 1'b0;
      end else if (ARM) begin
         r_cnt    <= '0;
         r_wr_ptr <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_cnt != CW'(DEPTH)) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
         if (r_state == S_DONE && SAMP_VALID) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_data <= '0;
      end else begin
         if (w_accept) begin
            r_mem[r_wr_ptr] <= SAMP_DATA;
         end
         r_rd_data <= r_mem[RD_ADDR];
      end
   end

   assign RD_DATA   = r_rd_data;
   assign SAMP_CNTS = r_cnt;
   assign WR_PTR    = r_wr_ptr;
   assign OVERFLOW  = r_ovf;

endmodule

// File: doc/samp_capture_buf.md
# samp_capture_buf

Parametrised sample capture buffer. It stores a stream of valid-qualified samples into a DEPTH-entry register array and exposes the array through a registered random-access read port. It adds arm/stop control, one-shot and circular capture modes, a saturating fill count and a sticky overflow flag. It sits after the sampler and before the readout/register-map logic, and is the generalised successor of the fixed 8-bit × 32 output register block.

## Interface
Parameters:
- DATA_W, 8 — sample width in bits (≥1).
- DEPTH, 32 — number of entries; power of two, ≥2.
- Derived (localparams, not overridable): AW = $clog2(DEPTH); CW = AW+1.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  — clock; all state updates on the rising edge.
- RST_N  in  1  — asynchronous active-low reset.
- SAMP_DATA  in  DATA_W  — sample data.
- SAMP_VALID  in  1  — SAMP_DATA is valid this cycle.
- ARM  in  1  — single-cycle pulse that clears the buffer state and starts a capture.
- MODE  in  1  — 0 = one-shot, 1 = circular; sampled only in the cycle ARM is high.
- STOP  in  1  — ends a circular capture; ignored in one-shot mode.
- RD_ADDR  in  AW  — read address.
- RD_DATA  out  DATA_W  — registered value of mem[RD_ADDR].
- SAMP_CNTS  out  CW  — number of stored samples, saturating at DEPTH.
- WR_PTR  out  AW  — next write index; in circular mode with SAMP_CNTS==DEPTH, this is the index of the oldest sample.
- BUSY  out  1  — state is CAPTURE.
- DONE  out  1  — state is DONE.
- OVERFLOW  out  1  — sticky flag: a sample arrived while in DONE.

## Operation
- Reset values: all memory entries 0, RD_DATA 0, SAMP_CNTS 0, WR_PTR 0, BUSY 0, DONE 0, OVERFLOW 0, state IDLE, latched mode 0.

State transitions:
- IDLE: SAMP_VALID is ignored and does not set OVERFLOW. ARM moves to CAPTURE.
- CAPTURE: each SAMP_VALID writes mem[WR_PTR] <= SAMP_DATA, then WR_PTR+1 (wraps modulo DEPTH) and SAMP_CNTS+1 (saturates at DEPTH).
  - One-shot: the write that brings SAMP_CNTS to DEPTH also moves the state to DONE.
  - Circular: writing continues and overwrites the oldest entry. STOP moves to DONE.
- DONE: no writes. SAMP_VALID sets OVERFLOW. Only ARM leaves DONE.

ARM behaviour:
- ARM is accepted in any state, including mid-capture.
- It clears SAMP_CNTS, WR_PTR and OVERFLOW, latches MODE, and enters CAPTURE.
- Memory contents are not cleared.
- If ARM and SAMP_VALID are high in the same cycle, ARM wins and the sample is dropped.

Simultaneous events:
- STOP together with SAMP_VALID in circular CAPTURE: the sample is written, then the state moves to DONE.
- STOP in IDLE, DONE or one-shot mode has no effect.

Read port:
- RD_DATA <= mem[RD_ADDR] every cycle, independent of state.
- A read of an address written in the same cycle returns the old data.

Reset mid-capture: everything returns to the reset values immediately (asynchronous reset).

## Timing
- Write latency: a sample accepted at edge N appears on RD_DATA at edge N+1 if RD_ADDR points to it.
- Read latency: 1 cycle from RD_ADDR to RD_DATA.
- SAMP_CNTS, WR_PTR, BUSY, DONE and OVERFLOW are registered and update at the same edge as the triggering write or control.
- BUSY and DONE are never high together.
- One-shot capture of DEPTH back-to-back samples: DONE rises at the edge of the DEPTH-th write, i.e. DEPTH cycles after the ARM edge.
- OVERFLOW rises one edge after the first SAMP_VALID seen in DONE.

## Configuration
- SAMP_CAP_DECIM_EN defined:
  - Adds an input port DECIM (in, 8 bits).
  - In CAPTURE, only every (DECIM+1)-th SAMP_VALID is stored: the 1st, then the (DECIM+2)-th, and so on.
  - The decimation counter counts only valid samples in CAPTURE, is cleared by ARM and reset, and reads 0 at reset.
  - DECIM=0 stores every sample.
  - Samples skipped by decimation do not affect SAMP_CNTS.
  - OVERFLOW in DONE is set by any SAMP_VALID, regardless of decimation.
- SAMP_CAP_DECIM_EN undefined: the DECIM port and counter do not exist, and every valid sample in CAPTURE is stored.

## Test plan
- Reset, then ARM with MODE=0 and 32 consecutive valid samples 0x00..0x1F (DATA_W=8, DEPTH=32) → DONE=1 at the 32nd write; SAMP_CNTS=32; WR_PTR=0; RD_ADDR=k returns k one cycle later.
- One-shot full, then 3 more valid samples → OVERFLOW=1 and memory unchanged. Then ARM → OVERFLOW=0, SAMP_CNTS=0, BUSY=1.
- ARM with MODE=1 and 40 samples 0x00..0x27, STOP asserted together with the 40th → DONE=1; SAMP_CNTS=32; WR_PTR=8; mem[8]=0x08 (oldest); mem[7]=0x27.
- ARM together with SAMP_VALID=1 (data 0xAA) while in CAPTURE with 5 samples stored → SAMP_CNTS=0 and WR_PTR=0 next cycle, 0xAA not written. Separately, assert RST_N low mid-capture → all outputs return to 0 asynchronously.
- SAMP_VALID in IDLE after reset → no write, SAMP_CNTS=0, OVERFLOW=0. Same-cycle write and read of address 3 → RD_DATA shows the old value.
- With SAMP_CAP_DECIM_EN and DECIM=2, one-shot, samples 0..95 → stored values 0,3,6,…,93; DONE at the 94th valid sample (value 93).
